// File: rtl/mux_sw_pkg.sv
// Shared definitions for the break-before-make N:1 switch: the FSM state
// encoding and the elaboration limits for the top-level parameters.
package mux_sw_pkg;

  localparam int MAX_NUM_IN = 16;
  localparam int MAX_GAP    = 15;

  // ACTIVE: passing the current channel; GAP: idle break interval;
  // LOAD: commit the pending channel and acknowledge.
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_GAP    = 2'd1,
    ST_LOAD   = 2'd2
  } sw_state_e;

endpackage

// File: rtl/mux_sw_sel.sv
// Purely combinational NUM_IN:1 selector over a packed input bus.
// Channel k lives at in_bus[k*WIDTH +: WIDTH]; an index with no matching
// channel yields zero.
module mux_sw_sel #(
  parameter int WIDTH  = 1,
  parameter int NUM_IN = 4,
  parameter int SW     = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SW-1:0]           sel,
  output logic [WIDTH-1:0]        dout
);

  // Compare-and-pick loop so non-power-of-two channel counts never index
  // past the end of the bus.
  always_comb begin
    dout = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SW'(k)) dout = in_bus[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_nx1_sw.sv
// Registered N:1 mux with break-before-make channel switching.
// A request to a different channel idles Q for GAP cycles, then loads the
// new channel and pulses SEL_ACK in the same cycle the new data reaches Q.
// Optional macro MUX_NX1_SW_HOLD_EN: when defined Q holds its last
// pre-switch value during the break; otherwise Q is zero during the break.
//
// Handshake: SEL_REQ is a single-cycle strobe sampled only while BUSY=0;
// each accepted request is answered by exactly one SEL_ACK or SEL_ERR pulse
// (never both), and strobes seen while BUSY=1 are dropped silently.
module mux_nx1_sw
  import mux_sw_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int NUM_IN = 4,
  parameter int GAP    = 2,
  localparam int SW    = $clog2(NUM_IN)
) (
  input  logic                    CLK,
  input  logic                    RSTB,
  input  logic [NUM_IN*WIDTH-1:0] IN,
  input  logic [SW-1:0]           SEL,
  input  logic                    SEL_REQ,
  output logic [WIDTH-1:0]        Q,
  output logic                    SEL_ACK,
  output logic                    SEL_ERR,
  output logic                    BUSY,
  output logic [SW-1:0]           CUR_SEL,
  output sw_state_e               dbg_state
);

  localparam int            CW       = $clog2(GAP + 1);
  localparam logic [SW:0]   NUM_IN_W = (SW + 1)'(NUM_IN);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

  generate
    if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
      $error("mux_nx1_sw: NUM_IN out of range 2..16");
    end
    if (GAP < 1 || GAP > MAX_GAP) begin : g_bad_gap
      $error("mux_nx1_sw: GAP out of range 1..15");
    end
  endgenerate

  sw_state_e         state_q, state_d;
  logic [SW-1:0]     cur_sel_q, cur_sel_d;
  logic [SW-1:0]     pend_q, pend_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [SW-1:0]     mux_idx;
  logic [WIDTH-1:0]  mux_out;
  logic [WIDTH-1:0]  gap_val;

  // LOAD reads the pending channel so the new data lands with SEL_ACK.
  assign mux_idx = (state_q == ST_LOAD) ? pend_q : cur_sel_q;

  mux_sw_sel #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SW     (SW)
  ) u_sel (
    .in_bus (IN),
    .sel    (mux_idx),
    .dout   (mux_out)
  );

`ifdef MUX_NX1_SW_HOLD_EN
  assign gap_val = q_q;
`else
  assign gap_val = '0;
`endif

  // Next-state and output decode for the ACTIVE/GAP/LOAD switch FSM.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      ST_ACTIVE: begin
        q_d = mux_out;
        if (SEL_REQ) begin
          if ({1'b0, SEL} >= NUM_IN_W) begin
            err_d = 1'b1;
          end else if (SEL == cur_sel_q) begin
            ack_d = 1'b1;
          end else begin
            // Break starts here: the old channel is not passed again.
            pend_d  = SEL;
            cnt_d   = '0;
            busy_d  = 1'b1;
            q_d     = gap_val;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        q_d = gap_val;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        cur_sel_d = pend_q;
        q_d       = mux_out;
        ack_d     = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_ACTIVE;
      end
      default: begin
        state_d = ST_ACTIVE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any switch in progress.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q   <= ST_ACTIVE;
      cur_sel_q <= '0;
      pend_q    <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign Q         = q_q;
  assign SEL_ACK   = ack_q;
  assign SEL_ERR   = err_q;
  assign BUSY      = busy_q;
  assign CUR_SEL   = cur_sel_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mux_nx1_sw.md
MUX_NX1_SW -- requirements
Module: mux_nx1_sw

Interface
REQ-001 Parameter WIDTH, default 1, bit width of each data input and of Q.
REQ-002 Parameter NUM_IN, default 4, number of data inputs (2..16).
REQ-003 Parameter GAP, default 2, break-before-make idle cycles on a select change (1..15).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RSTB  input  1  reset, asynchronous assert, active-low.
REQ-006 IN  input  NUM_IN*WIDTH  packed data inputs; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SEL  input  SW=$clog2(NUM_IN)  requested channel, sampled only when SEL_REQ=1.
REQ-008 SEL_REQ  input  1  single-cycle request to switch to channel SEL.
REQ-009 Q  output  WIDTH  registered mux output.
REQ-010 SEL_ACK  output  1  one-cycle pulse: the requested channel now drives Q.
REQ-011 SEL_ERR  output  1  one-cycle pulse: request rejected because SEL >= NUM_IN.
REQ-012 BUSY  output  1  high while a switch is in progress.
REQ-013 CUR_SEL  output  SW  channel currently selected.

Function
REQ-014 States: ACTIVE, GAP, LOAD; encoding is a shared enum.
REQ-015 ACTIVE: Q <= IN[CUR_SEL] every cycle (1-cycle latency input to Q).
REQ-016 ACTIVE with SEL_REQ=1, SEL==CUR_SEL: stay ACTIVE, SEL_ACK=1 the next cycle, no gap.
REQ-017 ACTIVE with SEL_REQ=1, SEL<NUM_IN, SEL!=CUR_SEL: latch SEL into pending register, go GAP, BUSY=1 the next cycle.
REQ-018 ACTIVE with SEL_REQ=1, SEL>=NUM_IN: stay ACTIVE, SEL_ERR=1 the next cycle, CUR_SEL unchanged.
REQ-019 GAP: gap counter counts GAP cycles; Q driven per REQ-027; then go LOAD.
REQ-020 LOAD: CUR_SEL <= pending, Q <= IN[pending], SEL_ACK=1 and BUSY=0 on the following cycle, return to ACTIVE.
REQ-021 Total request-to-ACK latency for a real switch is GAP+2 cycles; first new-channel data appears on Q in the same cycle as SEL_ACK.
REQ-022 SEL_REQ while BUSY=1 is ignored: no ACK, no ERR, pending unchanged.
REQ-023 SEL_ACK and SEL_ERR are never high in the same cycle.
REQ-024 Gap counter is ceil(log2(GAP+1)) bits and never wraps.

Reset
REQ-025 RSTB=0 immediately forces: state ACTIVE, CUR_SEL=0, pending=0, gap counter=0, Q=0, SEL_ACK=0, SEL_ERR=0, BUSY=0.
REQ-026 Reset asserted mid-switch abandons the switch; after release the block is in ACTIVE on channel 0 and no SEL_ACK is issued.

Configuration
REQ-027 Macro MUX_NX1_SW_HOLD_EN: defined -> Q holds the last pre-switch value during GAP; undefined -> Q is forced to all zeros during GAP and LOAD entry cycle.

Structure
REQ-028 Shared package mux_sw_pkg holds the state enum (ACTIVE/GAP/LOAD) and the limits MAX_NUM_IN=16, MAX_GAP=15.
REQ-029 One sub-module mux_sw_sel: purely combinational NUM_IN:1 WIDTH-bit selector from packed IN and a select index; top instantiates it once.
REQ-030 Parameter elaboration checks reject NUM_IN or GAP outside their ranges.

Verification
REQ-031 Reset release, NUM_IN=4, WIDTH=8, IN={0x44,0x33,0x22,0x11} -> Q=0x11 one cycle after release, CUR_SEL=0, BUSY=0.
REQ-032 SEL_REQ with SEL=2, GAP=2 -> BUSY high 3 cycles, Q=0x00 (macro off) or 0x11 (macro on) during gap, then Q=0x33 with SEL_ACK pulse at request+4.
REQ-033 SEL_REQ with SEL=CUR_SEL=2 -> SEL_ACK next cycle, BUSY stays 0, Q continuously 0x33.
REQ-034 NUM_IN=3, SEL_REQ with SEL=3 -> SEL_ERR pulse next cycle, no ACK, CUR_SEL unchanged.
REQ-035 Second SEL_REQ (SEL=1) during gap of switch to 2 -> ignored; single ACK, final CUR_SEL=2.
REQ-036 RSTB pulsed low during GAP -> outputs zero asynchronously, no ACK after release, CUR_SEL=0, Q=IN[0].
